// File: rtl/key_gesture_queue.sv
// Key gesture classifier (single / double / long) feeding a 4-entry event FIFO.
// A click opens a NUM_DC+1 cycle window; a second click inside it makes a double.
module key_gesture_queue #(
    parameter int NUM_DC = 24999999
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       click_in,
    input  logic       lpress_in,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic [2:0] evt_level,
    output logic       overflow
);

    localparam int CNT_W = ($clog2(NUM_DC + 1) > 25) ? $clog2(NUM_DC + 1) : 25;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WAIT2 = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        EVT_NONE   = 2'b00,
        EVT_SINGLE = 2'b01,
        EVT_DOUBLE = 2'b10,
        EVT_LONG   = 2'b11
    } evt_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_mem [4];
    logic [1:0]         r_wr_ptr;
    logic [1:0]         r_rd_ptr;
    logic [2:0]         r_level;
    logic               r_overflow;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_push;
    evt_t               w_push_code;
    logic               w_pop;
    logic               w_full;
    logic               w_wr_en;
    logic               w_drop;

    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_push_code = EVT_NONE;
        case (r_state)
            S_IDLE: begin
                if (lpress_in) begin
                    w_push      = 1'b1;
                    w_push_code = EVT_LONG;
                end else if (click_in) begin
                    w_state_nxt = S_WAIT2;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT2: begin
                // Priority: long press, then second click, then window timeout.
                if (lpress_in) begin
                    w_push      = 1'b1;
                    w_push_code = EVT_LONG;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (click_in) begin
                    w_push      = 1'b1;
                    w_push_code = EVT_DOUBLE;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(NUM_DC)) begin
                    w_push      = 1'b1;
                    w_push_code = EVT_SINGLE;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_pop   = evt_valid && evt_ready;
    assign w_full  = (r_level == 3'd4);
    // When full, a simultaneous pop frees the head slot, which is where wr_ptr points.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_level    <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; its contents are never visible while the level is zero.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_code;
        end
    end

    assign evt_valid = (r_level != 3'd0);
    assign evt_code  = evt_valid ? r_mem[r_rd_ptr] : 2'b00;
    assign evt_level = r_level;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_gesture_queue.sv
// Randomised and directed bench for key_gesture_queue with a timestamp-based
// gesture model and an expected-event scoreboard popped on each handshake.
module tb_key_gesture_queue;

    localparam int NUM_DC = 9;

    logic       clk = 1'b0;
    logic       rstn;
    logic       click_in;
    logic       lpress_in;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [2:0] evt_level;
    logic       overflow;

    key_gesture_queue #(.NUM_DC(NUM_DC)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .click_in  (click_in),
        .lpress_in (lpress_in),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_level (evt_level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue contents, sticky overflow, pending-click timestamp.
    int mq[$];
    int sb_q[$];
    bit m_ovf;
    bit m_pend;
    int m_pend_at;
    int n_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        sb_q.delete();
        m_ovf  = 1'b0;
        m_pend = 1'b0;
    endtask

    // Advance the model across the edge just taken, using the inputs held during the cycle before it.
    task automatic model_step();
        int  ev;
        bit  pop;
        bit  full;
        ev = 0;
        if (!rstn) begin
            model_clear();
        end else begin
            if (lpress_in) begin
                ev     = 3;
                m_pend = 1'b0;
            end else if (click_in) begin
                if (m_pend) begin
                    ev     = 2;
                    m_pend = 1'b0;
                end else begin
                    m_pend    = 1'b1;
                    m_pend_at = n_cyc;
                end
            end else if (m_pend && (n_cyc - m_pend_at == NUM_DC + 1)) begin
                ev     = 1;
                m_pend = 1'b0;
            end
            full = (mq.size() == 4);
            pop  = evt_ready && (mq.size() != 0);
            if (pop) void'(mq.pop_front());
            if (ev != 0) begin
                if (full && !pop) begin
                    m_ovf = 1'b1;
                end else begin
                    mq.push_back(ev);
                    sb_q.push_back(ev);
                end
            end
        end
        n_cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        model_step();
    endtask

    task automatic cycle(input bit c, input bit l, input bit r);
        step();
        click_in  = c;
        lpress_in = l;
        evt_ready = r;
    endtask

    task automatic do_reset(input int hold);
        step();
        rstn = 1'b0;
        model_clear();
        #1;
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_level", evt_level, 0);
        check("rst_ovf", overflow, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            click_in  = 1'b1;
            lpress_in = 1'($urandom_range(0, 1));
        end
        step();
        rstn      = 1'b1;
        click_in  = 1'b0;
        lpress_in = 1'b0;
    endtask

    // Monitor: mid-cycle compare against the model; pop the scoreboard on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            check("valid", evt_valid, (mq.size() != 0) ? 1 : 0);
            check("level", evt_level, mq.size());
            check("overflow", overflow, m_ovf);
            if (evt_valid && mq.size() != 0) check("head", evt_code, mq[0]);
            if (evt_valid && evt_ready) begin
                if (sb_q.size() == 0) check("code_unexpected", evt_code, 0);
                else check("code", evt_code, sb_q.pop_front());
            end
        end
    end

    initial begin
        int seen;
        rstn      = 1'b0;
        click_in  = 1'b0;
        lpress_in = 1'b0;
        evt_ready = 1'b0;
        model_clear();
        #1;
        check("init_valid", evt_valid, 0);
        check("init_level", evt_level, 0);
        check("init_ovf", overflow, 0);
        repeat (2) step();
        rstn = 1'b1;

        // Single click: head appears 11 cycles after the click cycle.
        cycle(1, 0, 1);
        seen = -1;
        for (int k = 1; k <= 15; k++) begin
            cycle(0, 0, 1);
            if (evt_valid && seen < 0) seen = k;
        end
        check("single_latency", seen, 11);

        // Double click, second click five cycles after the first.
        cycle(1, 0, 1);
        repeat (4) cycle(0, 0, 1);
        cycle(1, 0, 1);
        cycle(0, 0, 1);
        check("double_code", evt_code, 2);
        repeat (15) cycle(0, 0, 1);

        // Long press cancels a pending click; simultaneous click+lpress is long only.
        cycle(1, 0, 1);
        repeat (2) cycle(0, 0, 1);
        cycle(0, 1, 1);
        cycle(0, 0, 1);
        check("long_code", evt_code, 3);
        repeat (15) cycle(0, 0, 1);
        cycle(1, 1, 1);
        repeat (15) cycle(0, 0, 1);

        // Overflow: five long presses into a stalled queue.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
        end
        check("full_level", evt_level, 4);
        check("ovf_set", overflow, 1);
        repeat (6) cycle(0, 0, 1);
        check("drained", evt_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Push and pop together while full: a single lands as the fifth-in entry.
        do_reset(2);
        repeat (4) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
        end
        cycle(1, 0, 0);
        repeat (9) cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        check("pp_level", evt_level, 4);
        check("pp_ovf", overflow, 0);
        repeat (8) cycle(0, 0, 1);

        // Reset in the middle of a double-click window.
        cycle(1, 0, 1);
        repeat (3) cycle(0, 0, 1);
        do_reset(3);
        repeat (25) cycle(0, 0, 1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 1) == 1));
        end
        repeat (30) cycle(0, 0, 1);
        check("sb_drained", sb_q.size(), 0);
        check("final_level", evt_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
